// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// index-width and vector arithmetic, and the legacy keyboard/mouse/timer vectors.
package irq_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Vectors of the original three sources; channels 0/1/2 land here by default.
  localparam int unsigned VEC_KEYB  = 2;
  localparam int unsigned VEC_MOUSE = 4;
  localparam int unsigned VEC_TIMER = 6;

  localparam int unsigned VEC_BASE_DEF   = 2;
  localparam int unsigned VEC_STRIDE_DEF = 2;

  // Channel index width, never below one bit so a single-channel build still has a port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned vec_of(input int unsigned idx,
                                         input int unsigned base   = VEC_BASE_DEF,
                                         input int unsigned stride = VEC_STRIDE_DEF);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU/peripheral-facing signal bundle of the interrupt controller. The master
// side drives IRQ lines and CPU strobes; the slave side is the controller.
interface irq_ctrl_if #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned ADDR_W   = 16
) ();

  localparam int unsigned IDX_W = irq_pkg::idx_w(CHANNELS);

  logic [CHANNELS-1:0] irq;
  logic                intf;
  logic                ack;
  logic                eoi;
  logic                mask_we;
  logic [CHANNELS-1:0] mask;
  logic                ovr_clr;

  logic                irq_req;
  logic [ADDR_W-1:0]   vector;
  logic [IDX_W-1:0]    chan;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] inservice;
  logic [CHANNELS-1:0] overrun;

  modport master (
    output irq, intf, ack, eoi, mask_we, mask, ovr_clr,
    input  irq_req, vector, chan, pending, inservice, overrun
  );

  modport slave (
    input  irq, intf, ack, eoi, mask_we, mask, ovr_clr,
    output irq_req, vector, chan, pending, inservice, overrun
  );

endinterface

// File: rtl/irq_channel.sv
// One IRQ input: synchroniser, then either a registered level or a toggle
// detector feeding a saturating pending counter with a sticky overrun flag.
module irq_channel #(
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          LEVEL       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  input  logic run_i,
  input  logic ack_i,
  input  logic ovr_clr_i,
  output logic pending_o,
  output logic overrun_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  // NOTE: non-blocking assignments make every stage sample the previous stage's old value, so the chain shifts one flop per clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (LEVEL) begin : g_level
    logic lvl_q;
    logic unused_in;

    // Registered so a level request shows up on the same cycle a toggle would.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lvl_q <= 1'b0;
      end else begin
        lvl_q <= run_i & synced;
      end
    end

    assign unused_in = ack_i ^ ovr_clr_i;
    assign pending_o = lvl_q;
    assign overrun_o = 1'b0;

  end else begin : g_toggle
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             last_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             evt;

    // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
      cnt_d = cnt_q;
      ovr_d = ovr_q & ~ovr_clr_i;
      evt   = run_i & (synced ^ last_q);
      // An event and an ACK on the same channel cancel out.
      if (evt && !ack_i) begin
        if (cnt_q == CNT_MAX) begin
          ovr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (ack_i && !evt && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        last_q <= 1'b0;
        cnt_q  <= '0;
        ovr_q  <= 1'b0;
      end else begin
        last_q <= synced;
        cnt_q  <= cnt_d;
        ovr_q  <= ovr_d;
      end
    end

    assign pending_o = (cnt_q != '0);
    assign overrun_o = ovr_q;
  end

endmodule

// File: rtl/irq_ctrl.sv
// N-channel interrupt controller: prime-then-run FSM, mask and in-service
// registers, fixed-priority selection with nesting, and registered CPU outputs.
module irq_ctrl import irq_pkg::*; #(
  parameter int unsigned         CHANNELS    = 8,
  parameter int unsigned         CNT_W       = 3,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         ADDR_W      = 16,
  parameter int unsigned         VEC_BASE    = 2,
  parameter int unsigned         VEC_STRIDE  = 2,
  parameter logic [CHANNELS-1:0] LEVEL_MODE  = '0,
  parameter logic [CHANNELS-1:0] MASK_RESET  = '1
) (
  input logic        clk_i,
  input logic        rst_ni,
  irq_ctrl_if.slave  bus
);

  localparam int unsigned         IDX_W      = idx_w(CHANNELS);
  localparam int unsigned         PRIME_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [PRIME_W-1:0]  PRIME_LAST = PRIME_W'(SYNC_STAGES);

  state_e              state_q, state_d;
  logic [PRIME_W-1:0]  prime_q, prime_d;
  logic                run;

  logic [CHANNELS-1:0] mask_q;
  logic [CHANNELS-1:0] is_q, is_d;
  logic [CHANNELS-1:0] pending, overrun;
  logic [CHANNELS-1:0] ack_vec;
  logic [CHANNELS-1:0] lowest_is, below_is, eligible;
  logic                ack_acc;
  logic                any_elig;
  logic [IDX_W-1:0]    winner;

  logic                req_q, req_d;
  logic [IDX_W-1:0]    chan_q;
  logic [ADDR_W-1:0]   vec_q, vec_d;

  // Prime window lets last-seen registers catch up with the synchronisers
  // so levels present at reset release are not mistaken for toggles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PRIME;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    case (state_q)
      PRIME: begin
        if (prime_q == PRIME_LAST) begin
          state_d = RUN;
        end else begin
          prime_d = prime_q + PRIME_W'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    run = (state_q == RUN);
  end

  assign ack_acc = bus.ack & req_q;

  always_comb begin
    ack_vec = '0;
    if (ack_acc) begin
      ack_vec[chan_q] = 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    irq_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .LEVEL       (LEVEL_MODE[c])
    ) u_channel (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .irq_i     (bus.irq[c]),
      .run_i     (run),
      .ack_i     (ack_vec[c]),
      .ovr_clr_i (bus.ovr_clr),
      .pending_o (pending[c]),
      .overrun_o (overrun[c])
    );
  end

  // EOI retires the lowest set bit before the ACK marks the new channel.
  always_comb begin
    is_d = is_q;
    if (bus.eoi) begin
      is_d = is_d & (is_d - CHANNELS'(1));
    end
    is_d = is_d | ack_vec;
  end

  // Isolating the lowest in-service bit and subtracting one gives the set of
  // strictly higher-priority channels; an empty register yields all ones.
  always_comb begin
    lowest_is = is_q & (~is_q + CHANNELS'(1));
    below_is  = lowest_is - CHANNELS'(1);
    eligible  = pending & ~mask_q & below_is;
    any_elig  = |eligible;
    winner    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = IDX_W'(i);
      end
    end
  end

  always_comb begin
    req_d = run & bus.intf & any_elig & ~ack_acc;
    vec_d = ADDR_W'(vec_of(32'(winner), VEC_BASE, VEC_STRIDE));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= MASK_RESET;
      is_q   <= '0;
      req_q  <= 1'b0;
      chan_q <= '0;
      vec_q  <= '0;
    end else begin
      if (bus.mask_we) begin
        mask_q <= bus.mask;
      end
      is_q   <= is_d;
      req_q  <= req_d;
      chan_q <= winner;
      vec_q  <= vec_d;
    end
  end

  assign bus.irq_req   = req_q;
  assign bus.vector    = vec_q;
  assign bus.chan      = chan_q;
  assign bus.pending   = pending;
  assign bus.inservice = is_q;
  assign bus.overrun   = overrun;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomised checks of irq_ctrl against a transaction-level model
// that tracks pending counts, in-service set, mask and overrun per channel.
module tb_irq_ctrl;
  import irq_pkg::*;

  localparam int CH         = 4;
  localparam int CNT_W      = 2;
  localparam int CNT_MAX    = 3;
  localparam int SYNC       = 2;
  localparam int AW         = 16;
  localparam int VEC_BASE   = 2;
  localparam int VEC_STRIDE = 2;
  localparam int SETTLE     = SYNC + 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  irq_ctrl_if #(.CHANNELS(CH), .ADDR_W(AW)) bus ();

  irq_ctrl #(
    .CHANNELS    (CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC),
    .ADDR_W      (AW),
    .VEC_BASE    (VEC_BASE),
    .VEC_STRIDE  (VEC_STRIDE),
    .LEVEL_MODE  (4'b1000),
    .MASK_RESET  (4'b1111)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [CH-1:0] lvl_mode = 4'b1000;
  int  cnt [CH];
  bit  ovr [CH];
  bit  msk [CH];
  bit  isv [CH];
  bit  intf_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      cnt[c] = 0; ovr[c] = 1'b0; msk[c] = 1'b1; isv[c] = 1'b0;
    end
  endtask

  function automatic bit m_pend(input int c);
    return lvl_mode[c] ? bit'(bus.irq[c]) : (cnt[c] != 0);
  endfunction

  function automatic int m_winner();
    int lim;
    lim = CH;
    for (int c = CH - 1; c >= 0; c--) if (isv[c]) lim = c;
    for (int c = 0; c < CH; c++) if (m_pend(c) && !msk[c] && c < lim) return c;
    return -1;
  endfunction

  task automatic m_eoi();
    for (int c = 0; c < CH; c++) if (isv[c]) begin isv[c] = 1'b0; break; end
  endtask

  task automatic m_accept(input int w);
    isv[w] = 1'b1;
    if (!lvl_mode[w]) cnt[w]--;
  endtask

  task automatic check_state(input string tag);
    logic [CH-1:0] ep, ei, eo;
    int w;
    for (int c = 0; c < CH; c++) begin
      ep[c] = m_pend(c); ei[c] = isv[c]; eo[c] = ovr[c];
    end
    w = m_winner();
    check({tag, ".pending"},   32'(bus.pending),   32'(ep));
    check({tag, ".inservice"}, 32'(bus.inservice), 32'(ei));
    check({tag, ".overrun"},   32'(bus.overrun),   32'(eo));
    check({tag, ".req"},       32'(bus.irq_req),   32'(intf_m && w >= 0));
    if (intf_m && w >= 0) begin
      check({tag, ".vector"}, 32'(bus.vector), 32'(VEC_BASE + w * VEC_STRIDE));
      check({tag, ".chan"},   32'(bus.chan),   32'(w));
    end
  endtask

  task automatic pulse(input bit a, input bit e, input bit mw, input bit oc);
    bus.ack = a; bus.eoi = e; bus.mask_we = mw; bus.ovr_clr = oc;
    @(negedge clk_i);
    bus.ack = 1'b0; bus.eoi = 1'b0; bus.mask_we = 1'b0; bus.ovr_clr = 1'b0;
  endtask

  task automatic do_toggle(input int c);
    bus.irq[c] = ~bus.irq[c];
    if (!lvl_mode[c]) begin
      if (cnt[c] == CNT_MAX) ovr[c] = 1'b1; else cnt[c]++;
    end
    tick(SETTLE);
    check_state("toggle");
  endtask

  task automatic do_ack();
    int w;
    bit acc;
    w = m_winner();
    acc = intf_m && w >= 0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    if (acc) begin
      check("ack.req_forced_low", 32'(bus.irq_req), 32'd0);
      m_accept(w);
    end
    tick(SETTLE);
    check_state("ack");
  endtask

  task automatic do_eoi();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    m_eoi();
    tick(SETTLE);
    check_state("eoi");
  endtask

  task automatic do_ack_eoi();
    int w;
    bit acc;
    w = m_winner();
    acc = intf_m && w >= 0;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    m_eoi();
    if (acc) m_accept(w);
    tick(SETTLE);
    check_state("ack_eoi");
  endtask

  task automatic do_mask(input logic [CH-1:0] m, input bit with_ack);
    int w;
    bit acc;
    w = m_winner();
    acc = with_ack && intf_m && w >= 0;
    bus.mask = m;
    pulse(with_ack, 1'b0, 1'b1, 1'b0);
    if (acc) m_accept(w);
    for (int c = 0; c < CH; c++) msk[c] = m[c];
    tick(SETTLE);
    check_state("mask");
  endtask

  task automatic do_ovr_clr();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < CH; c++) ovr[c] = 1'b0;
    tick(SETTLE);
    check_state("ovr_clr");
  endtask

  task automatic set_intf(input bit v);
    bus.intf = v;
    intf_m = v;
    tick(SETTLE);
    check_state("intf");
  endtask

  // Toggle channel c so its event lands on the same clock as an ACK and/or overrun clear.
  task automatic toggle_with(input int c, input bit a, input bit oc);
    int w;
    bit acc;
    w = m_winner();
    acc = a && intf_m && w >= 0;
    bus.irq[c] = ~bus.irq[c];
    tick(SYNC);
    pulse(a, 1'b0, 1'b0, oc);
    if (oc) for (int d = 0; d < CH; d++) ovr[d] = 1'b0;
    if (!(acc && w == c)) begin
      if (cnt[c] == CNT_MAX) ovr[c] = 1'b1; else cnt[c]++;
    end
    if (acc) begin
      isv[w] = 1'b1;
      if (w != c && !lvl_mode[w]) cnt[w]--;
    end
    tick(SETTLE);
    check_state("toggle_with");
  endtask

  task automatic drain();
    bit busy;
    for (int k = 0; k < 40; k++) begin
      busy = 1'b0;
      for (int c = 0; c < CH; c++) if (isv[c]) busy = 1'b1;
      if (busy) do_eoi();
      else if (intf_m && m_winner() >= 0) do_ack();
      else break;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},       32'(bus.irq_req),   32'd0);
    check({tag, ".vector"},    32'(bus.vector),    32'd0);
    check({tag, ".chan"},      32'(bus.chan),      32'd0);
    check({tag, ".pending"},   32'(bus.pending),   32'd0);
    check({tag, ".inservice"}, 32'(bus.inservice), 32'd0);
    check({tag, ".overrun"},   32'(bus.overrun),   32'd0);
  endtask

  initial begin
    bus.irq = 4'b0001; bus.intf = 1'b1; intf_m = 1'b1;
    bus.ack = 1'b0; bus.eoi = 1'b0; bus.mask_we = 1'b0; bus.mask = '0; bus.ovr_clr = 1'b0;
    m_reset();

    // Reset with IRQ0 held high: nothing must be counted after release
    tick(3);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("prime.no_req", 32'(bus.irq_req), 32'd0);
    end
    check("prime.pending", 32'(bus.pending), 32'd0);

    // Reset mask hides a toggle; clearing the mask presents it
    do_toggle(1);
    do_mask(4'b0000, 1'b0);
    check("first.vector", 32'(bus.vector), 32'(VEC_MOUSE));
    check("first.chan",   32'(bus.chan),   32'd1);
    do_ack();
    check("first.inservice", 32'(bus.inservice), 32'b0010);
    do_eoi();

    // Toggle to request latency is SYNC_STAGES+2 cycles
    bus.irq[1] = ~bus.irq[1];
    cnt[1]++;
    for (int k = 1; k <= SYNC + 2; k++) begin
      tick(1);
      check("latency.req", 32'(bus.irq_req), 32'(k == SYNC + 2));
    end
    check_state("latency");
    drain();

    // Saturation and overrun on channel 2, then drain and clear
    repeat (5) do_toggle(2);
    check("sat.overrun", 32'(bus.overrun), 32'b0100);
    repeat (3) begin do_ack(); do_eoi(); end
    check("sat.drained", 32'(bus.pending), 32'd0);
    do_ovr_clr();
    check("sat.cleared", 32'(bus.overrun), 32'd0);

    // Nesting: channel 2 in service, only channel 0 may preempt
    do_toggle(2);
    do_ack();
    do_toggle(2);
    do_toggle(0);
    check("nest.vector0", 32'(bus.vector), 32'(VEC_KEYB));
    do_ack();
    do_eoi();
    do_eoi();
    check("nest.vector2", 32'(bus.vector), 32'(VEC_TIMER));
    drain();

    // EOI and ACK in one cycle: old bit cleared, new bit set
    do_toggle(2);
    do_ack();
    do_toggle(0);
    do_ack_eoi();
    check("eoi_ack.inservice", 32'(bus.inservice), 32'b0001);
    drain();

    // Event and ACK on the same saturated channel: no count change, no overrun
    repeat (3) do_toggle(2);
    toggle_with(2, 1'b1, 1'b0);
    check("evt_ack.overrun", 32'(bus.overrun), 32'd0);
    drain();

    // Overrun clear colliding with a new overrun keeps the flag
    repeat (4) do_toggle(1);
    toggle_with(1, 1'b0, 1'b1);
    check("clr_vs_ovr.flag", 32'(bus.overrun[1]), 32'd1);
    do_ovr_clr();
    drain();

    // Masking the presented channel with an ACK in the same cycle
    do_toggle(0);
    do_mask(4'b0001, 1'b1);
    check("mask_ack.inservice", 32'(bus.inservice), 32'b0001);
    do_mask(4'b0000, 1'b0);
    drain();

    // Interrupt enable low gates the request but keeps pending state
    set_intf(1'b0);
    do_toggle(0);
    set_intf(1'b1);
    drain();

    // Level channel 3: re-request after EOI, pending follows level
    do_toggle(3);
    do_ack();
    do_eoi();
    check("level.rereq", 32'(bus.irq_req), 32'd1);
    bus.irq[3] = 1'b0;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick(1);
      check("level.drop", 32'(bus.pending[3]), 32'(k <= SYNC));
    end
    tick(SETTLE);
    check_state("level.dropped");
    drain();

    // Randomised operation mix against the model
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: do_toggle(int'($urandom_range(0, CH - 1)));
        3:       do_ack();
        4:       do_eoi();
        5:       do_mask(CH'($urandom_range(0, 15)) & CH'($urandom_range(0, 15)), 1'b0);
        6:       do_ovr_clr();
        default: set_intf($urandom_range(0, 3) != 0);
      endcase
    end

    // Reset in the middle of activity
    do_toggle(2);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_reset();
    tick(2);
    rst_ni = 1'b1;
    tick(SETTLE + 4);
    check_state("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller that sits between peripheral IRQ sources and the 8-bit CPU core.
- Generalises the CPU's fixed three-source toggle detection (keyboard, mouse, timer) to N channels.
- Adds input synchronisers, per-channel pending counters so no toggle is lost, masking, fixed priority with in-service nesting, overrun flags and vector generation.
- CPU sees one request line, a vector address, an ACK pulse on interrupt entry and an EOI pulse on RETI.

Parameters:
- CHANNELS, 8, number of IRQ inputs; 1..16.
- CNT_W, 3, width of the per-channel pending counter; saturates at 2^CNT_W-1.
- SYNC_STAGES, 2, synchroniser depth; >=2.
- ADDR_W, 16, vector width.
- VEC_BASE, 2, vector of channel 0.
- VEC_STRIDE, 2, vector spacing. Channel 0/1/2 then map to 2/4/6, matching the existing keyb/mouse/timer map.
- LEVEL_MODE, 0, CHANNELS-bit; bit=1 makes that channel level-sensitive (high=request) instead of toggle-sensitive.
- MASK_RESET, all-ones, reset value of the mask register.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- I_IRQ  in  CHANNELS  raw IRQ inputs; toggle or level per LEVEL_MODE.
- I_INTF  in  1  CPU interrupt-enable flag; gates O_IRQ_REQ.
- I_ACK  in  1  one-cycle pulse: CPU accepted the presented vector.
- I_EOI  in  1  one-cycle pulse: CPU executed RETI.
- I_MASK_WE  in  1  mask write strobe.
- I_MASK  in  CHANNELS  mask data; 1 = masked.
- I_OVR_CLR  in  1  clears all overrun flags.
- O_IRQ_REQ  out  1  registered interrupt request.
- O_VECTOR  out  ADDR_W  registered vector; valid while O_IRQ_REQ=1.
- O_CHAN  out  clog2(CHANNELS)  registered index of the presented channel.
- O_PENDING  out  CHANNELS  per-channel counter!=0 (toggle mode) or synced level (level mode).
- O_INSERVICE  out  CHANNELS  in-service register.
- O_OVERRUN  out  CHANNELS  sticky overrun flags.

Behaviour:
- Reset (asynchronous): all outputs 0, sync flops 0, counters 0, in-service 0, overrun 0, mask=MASK_RESET, FSM=PRIME.
- FSM PRIME: runs SYNC_STAGES+1 cycles after RESET_N deasserts. Last-seen registers track the synced inputs; no counting and no requests. Then moves to RUN. RUN exits only on reset.
- Toggle channel, event detection: an event is synced value != last-seen. Last-seen updates every cycle.
- Toggle channel, counter: increments on an event. At max it holds and sets O_OVERRUN[ch].
- Toggle channel, ACK and event in the same cycle on that channel: counter unchanged; no overrun unless the counter is already at max and no ACK occurs.
- Level channel: pending = synced level. No counter; O_OVERRUN is never set.
- Eligible channel: pending, and not masked, and its index is lower than the lowest set in-service bit (or in-service is 0).
- Request: winner = lowest eligible index. Next cycle O_IRQ_REQ = I_INTF and eligible-exists, O_CHAN = winner, O_VECTOR = VEC_BASE + winner*VEC_STRIDE, truncated to ADDR_W.
- Latency: I_IRQ toggle to O_IRQ_REQ high is SYNC_STAGES+2 cycles when I_INTF=1 and the channel is unmasked.
- ACK accepted only when O_IRQ_REQ=1; it acts on O_CHAN as registered that cycle.
  - Counter of that channel decrements (toggle mode).
  - O_INSERVICE[O_CHAN] is set.
  - O_IRQ_REQ is forced 0 for the following cycle, then re-evaluated.
  - ACK while O_IRQ_REQ=0: ignored.
- EOI: clears the lowest set in-service bit. EOI with in-service=0: ignored.
- EOI and ACK in the same cycle: EOI clear is applied first, then the ACK set.
- Masking: a masked channel keeps counting but is never presented. A mask write affects O_IRQ_REQ from the cycle after next. Masking the presented channel while O_IRQ_REQ=1 drops the request next cycle; an ACK in the write cycle is still honoured.
- I_INTF=0: O_IRQ_REQ=0 next cycle; pending state is preserved.
- I_OVR_CLR: clears all overrun flags. A simultaneous new overrun wins (flag stays 1).
- Reset mid-operation: everything returns to reset values, pending events are discarded, PRIME re-runs.

Decomposition:
- Package irq_pkg:
  - state enum {PRIME, RUN}.
  - idx_w(CHANNELS) clog2 function.
  - vec_of(idx) function.
  - Default vector constants 2/4/6 for keyb/mouse/timer.
- Sub-module irq_channel, instanced per channel: synchroniser, last-seen register, edge detect, saturating counter, overrun flag, level/toggle select.
- Top level holds the FSM, mask, in-service register, priority encoder and output registers.

Test Plan:
- Reset with I_IRQ[0]=1 held, then release → no request ever; O_PENDING=0 after PRIME.
- CHANNELS=3, I_INTF=1, mask=0, toggle I_IRQ[1] → O_IRQ_REQ=1 at +4 cycles, O_VECTOR=0x0004, O_CHAN=1; ACK → O_INSERVICE=3'b010, O_IRQ_REQ=0.
- Toggle ch2 5 times with CNT_W=2 → counter 3, O_OVERRUN[2]=1; three ACK/EOI pairs drain it to 0; I_OVR_CLR clears the flag.
- Ch2 in service, toggle ch2 and ch0 → only vector 0x0002 presented. ACK, EOI, EOI → then 0x0006 presented.
- I_MASK_WE with mask=3'b001, toggle ch0 → no request; O_PENDING[0]=1. Unmask → request within 2 cycles.
- LEVEL_MODE[1]=1, hold I_IRQ[1]=1 through ACK and EOI → re-request after EOI; drop the level → O_PENDING[1]=0 after SYNC_STAGES+1 cycles.
